autoconfig_host: RTL and testbench



---
 rtl/autoconfig_host.sv | 260 ++++++++++++++++++++++++++
 tb/tb_autoconfig_host.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/autoconfig_host.sv
// rtl/autoconfig_host.sv - Zorro II AUTOCONFIG initiator walking the $E8xxxx config chain
// Reads each card's type nibbles, assigns an aligned Fast RAM base or shuts the card up.
module autoconfig_host #(
  parameter logic [7:0] MEM_BASE    = 8'h20,
  parameter logic [7:0] MEM_TOP     = 8'hA0,
  parameter int         TIMEOUT_CYC = 64,
  parameter bit         AUTO_START  = 1'b1
) (
  input  logic       cpu_clk,
  input  logic       cpu_nreset,
  input  logic       start,
  output logic [7:0] ah_o,
  output logic [5:0] al_o,
  output logic [3:0] d_o,
  output logic       d_oe,
  input  logic [3:0] d_i,
  output logic       nas_o,
  output logic       nuds_o,
  output logic       rnw_o,
  input  logic       dtack_i,
  output logic       nconfigin_o,
  output logic       busy,
  output logic       done,
  output logic [2:0] cards,
  output logic [2:0] shut_cnt,
  output logic [7:0] next_free
);

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0] CFG_AH = 8'hE8;

  typedef enum logic [2:0] {B_IDLE, B_ADDR, B_STRB, B_WAIT, B_END} bus_state_t;
  typedef enum logic [2:0] {
    T_IDLE, T_READ, T_EVAL, T_WR_LO, T_WR_HI, T_SHUT, T_SETTLE, T_DONE
  } top_state_t;

  bus_state_t    bus_st;
  top_state_t    top_st;
  logic [1:0]    dtack_sync;
  logic [TW-1:0] to_cnt;
  logic          bus_to;
  logic [3:0]    rd_nib;
  logic          auto_pend;
  logic [3:0]    idx;
  logic [1:0]    type_hi;
  logic [2:0]    size_r;
  logic [1:0]    settle_cnt;

  logic          req_valid;
  logic [5:0]    req_al;
  logic [3:0]    req_d;
  logic          req_rnw;
  logic [8:0]    s9;
  logic [8:0]    base9;
  logic [8:0]    end9;
  logic          fits;
  logic          run_go;

  // Allocation in 64KB units; 9 bits so rounding past $FF is still caught by the top check.
  always_comb begin
    s9    = (size_r == 3'd0) ? 9'd128 : (9'd1 << (size_r - 3'd1));
    base9 = ({1'b0, next_free} + s9 - 9'd1) & ~(s9 - 9'd1);
    end9  = base9 + s9;
    fits  = (end9 <= {1'b0, MEM_TOP});
  end

  always_comb begin
    req_valid = 1'b0;
    req_al    = 6'h00;
    req_d     = 4'h0;
    req_rnw   = 1'b1;
    case (top_st)
      T_READ: begin
        req_valid = 1'b1;
        req_al    = (idx < 4'd5) ? {2'b00, idx} : {2'b00, idx} + 6'd3;
      end
      T_WR_LO: begin
        req_valid = 1'b1;
        req_al    = 6'h25;
        req_d     = base9[3:0];
        req_rnw   = 1'b0;
      end
      T_WR_HI: begin
        req_valid = 1'b1;
        req_al    = 6'h24;
        req_d     = base9[7:4];
        req_rnw   = 1'b0;
      end
      T_SHUT: begin
        req_valid = 1'b1;
        req_al    = 6'h26;
        req_d     = 4'h0;
        req_rnw   = 1'b0;
      end
      default: ;
    endcase
  end

  assign run_go = ((top_st == T_IDLE) && (start || auto_pend)) ||
                  ((top_st == T_DONE) && start);

  always_ff @(posedge cpu_clk or negedge cpu_nreset) begin
    if (!cpu_nreset) begin
      bus_st      <= B_IDLE;
      top_st      <= T_IDLE;
      dtack_sync  <= 2'b00;
      to_cnt      <= '0;
      bus_to      <= 1'b0;
      rd_nib      <= 4'h0;
      auto_pend   <= AUTO_START;
      idx         <= 4'd0;
      type_hi     <= 2'b00;
      size_r      <= 3'd0;
      settle_cnt  <= 2'd0;
      ah_o        <= 8'h00;
      al_o        <= 6'h00;
      d_o         <= 4'h0;
      d_oe        <= 1'b0;
      nas_o       <= 1'b1;
      nuds_o      <= 1'b1;
      rnw_o       <= 1'b1;
      nconfigin_o <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      cards       <= 3'd0;
      shut_cnt    <= 3'd0;
      next_free   <= MEM_BASE;
    end else begin
      dtack_sync <= {dtack_sync[0], dtack_i};

      case (bus_st)
        B_IDLE: begin
          if (req_valid) begin
            bus_st <= B_ADDR;
            ah_o   <= CFG_AH;
            al_o   <= req_al;
            rnw_o  <= req_rnw;
            d_o    <= req_d;
            d_oe   <= !req_rnw;
          end
        end
        B_ADDR: begin
          bus_st <= B_STRB;
          nas_o  <= 1'b0;
          nuds_o <= 1'b0;
        end
        B_STRB: begin
          bus_st <= B_WAIT;
          to_cnt <= '0;
        end
        B_WAIT: begin
          if (dtack_sync[1]) begin
            rd_nib <= d_i;
            bus_to <= 1'b0;
            nas_o  <= 1'b1;
            nuds_o <= 1'b1;
            bus_st <= B_END;
          end else if (to_cnt == TO_LAST) begin
            bus_to <= 1'b1;
            nas_o  <= 1'b1;
            nuds_o <= 1'b1;
            bus_st <= B_END;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        B_END: begin
          // Data drivers stay on one cycle past the strobe for hold time.
          bus_st <= B_IDLE;
          d_oe   <= 1'b0;
          rnw_o  <= 1'b1;
        end
        default: bus_st <= B_IDLE;
      endcase

      if (run_go) begin
        top_st      <= T_READ;
        idx         <= 4'd0;
        auto_pend   <= 1'b0;
        busy        <= 1'b1;
        done        <= 1'b0;
        nconfigin_o <= 1'b0;
        cards       <= 3'd0;
        shut_cnt    <= 3'd0;
        next_free   <= MEM_BASE;
      end else begin
        case (top_st)
          T_READ: begin
            if (bus_st == B_END) begin
              if (bus_to) begin
                top_st <= T_DONE;
                busy   <= 1'b0;
                done   <= 1'b1;
              end else begin
                // Only the raw type nibbles at $00/$02 steer the allocation.
                if (idx == 4'd0) type_hi <= rd_nib[3:2];
                if (idx == 4'd1) size_r  <= rd_nib[2:0];
                if (idx == 4'd8) top_st  <= T_EVAL;
                idx <= idx + 4'd1;
              end
            end
          end
          T_EVAL: begin
            top_st <= ((type_hi == 2'b11) && fits) ? T_WR_LO : T_SHUT;
          end
          T_WR_LO: begin
            if (bus_st == B_END) begin
              if (bus_to) begin
                top_st <= T_DONE;
                busy   <= 1'b0;
                done   <= 1'b1;
              end else begin
                top_st <= T_WR_HI;
              end
            end
          end
          T_WR_HI: begin
            if (bus_st == B_END) begin
              if (bus_to) begin
                top_st <= T_DONE;
                busy   <= 1'b0;
                done   <= 1'b1;
              end else begin
                next_free  <= end9[7:0];
                cards      <= (cards == 3'd7) ? cards : cards + 3'd1;
                settle_cnt <= 2'd0;
                top_st     <= T_SETTLE;
              end
            end
          end
          T_SHUT: begin
            if (bus_st == B_END) begin
              if (bus_to) begin
                top_st <= T_DONE;
                busy   <= 1'b0;
                done   <= 1'b1;
              end else begin
                shut_cnt   <= (shut_cnt == 3'd7) ? shut_cnt : shut_cnt + 3'd1;
                settle_cnt <= 2'd0;
                top_st     <= T_SETTLE;
              end
            end
          end
          T_SETTLE: begin
            // Give the card's /CONFIGOUT time to reach the next card.
            if (settle_cnt == 2'd3) begin
              idx    <= 4'd0;
              top_st <= T_READ;
            end else begin
              settle_cnt <= settle_cnt + 2'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_autoconfig_host.sv
// tb/tb_autoconfig_host.sv - directed bench for autoconfig_host with a chained card model
module tb_autoconfig_host;

  logic       cpu_clk = 1'b0;
  logic       cpu_nreset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] ah_o;
  logic [5:0] al_o;
  logic [3:0] d_o;
  logic       d_oe;
  logic [3:0] d_i;
  logic       nas_o;
  logic       nuds_o;
  logic       rnw_o;
  logic       dtack_i;
  logic       nconfigin_o;
  logic       busy;
  logic       done;
  logic [2:0] cards;
  logic [2:0] shut_cnt;
  logic [7:0] next_free;

  autoconfig_host dut (
    .cpu_clk     (cpu_clk),
    .cpu_nreset  (cpu_nreset),
    .start       (start),
    .ah_o        (ah_o),
    .al_o        (al_o),
    .d_o         (d_o),
    .d_oe        (d_oe),
    .d_i         (d_i),
    .nas_o       (nas_o),
    .nuds_o      (nuds_o),
    .rnw_o       (rnw_o),
    .dtack_i     (dtack_i),
    .nconfigin_o (nconfigin_o),
    .busy        (busy),
    .done        (done),
    .cards       (cards),
    .shut_cnt    (shut_cnt),
    .next_free   (next_free)
  );

  always #5 cpu_clk = ~cpu_clk;

  int checks = 0;
  int errors = 0;

  int         n_cards = 0;
  logic [7:0] card_type [4];
  int         pass_base = 0;
  int         rd_base = 0;
  int         wr_base = 0;
  bit         ack_block = 1'b0;

  int         pass_cnt = 0;
  int         rd_cnt = 0;
  int         wr_cnt = 0;
  int         low_run = 0;
  int         last_low = 0;
  bit         nas_prev = 1'b1;
  bit         pass_pend = 1'b0;
  logic [5:0] rd_al [256];
  logic [5:0] wr_al [256];
  logic [3:0] wr_d  [256];

  logic [5:0] exp_rd [9] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h08, 6'h09, 6'h0A, 6'h0B};

  int   ci;
  logic card_sel;

  // Card chain: the selected card answers while /AS is low and moves on after $48/$4C.
  always_comb begin
    ci       = pass_cnt - pass_base;
    card_sel = !nconfigin_o && (ci >= 0) && (ci < n_cards);
    dtack_i  = card_sel && !nas_o && !(ack_block && !rnw_o && (al_o == 6'h24));
    d_i      = 4'hE;
    if (card_sel && al_o == 6'h00) d_i = card_type[ci[1:0]][7:4];
    else if (card_sel && al_o == 6'h01) d_i = card_type[ci[1:0]][3:0];
  end

  always @(negedge cpu_clk) begin
    if (!nas_o && nas_prev) begin
      if (rnw_o) begin
        rd_al[rd_cnt[7:0]] = al_o;
        rd_cnt++;
      end else begin
        wr_al[wr_cnt[7:0]] = al_o;
        wr_d[wr_cnt[7:0]]  = d_oe ? d_o : 4'hF;
        wr_cnt++;
      end
    end
    if (!nas_o) low_run++;
    else if (!nas_prev) begin
      last_low = low_run;
      low_run  = 0;
    end
    if (!nas_o && !rnw_o && dtack_i && (al_o == 6'h24 || al_o == 6'h26)) pass_pend = 1'b1;
    else if (nas_o && pass_pend) begin
      pass_cnt++;
      pass_pend = 1'b0;
    end
    nas_prev = nas_o;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic setup_chain(input int n, input logic [7:0] t0, input logic [7:0] t1,
                             input logic [7:0] t2);
    n_cards      = n;
    card_type[0] = t0;
    card_type[1] = t1;
    card_type[2] = t2;
    card_type[3] = 8'h00;
    pass_base    = pass_cnt;
    rd_base      = rd_cnt;
    wr_base      = wr_cnt;
  endtask

  task automatic pulse_start();
    @(negedge cpu_clk);
    start = 1'b1;
    @(negedge cpu_clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 4000) begin
      @(negedge cpu_clk);
      n++;
    end
    check(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic check_wr(input string tag, input int k, input logic [5:0] al, input logic [3:0] d);
    check({tag, "_al"}, {26'd0, wr_al[(wr_base + k) % 256]}, {26'd0, al});
    check({tag, "_d"},  {28'd0, wr_d[(wr_base + k) % 256]},  {28'd0, d});
  endtask

  initial begin
    int n;

    // Reset state
    setup_chain(1, 8'hE6, 8'h00, 8'h00);
    repeat (3) @(negedge cpu_clk);
    check("rst_nas", {31'd0, nas_o}, 32'd1);
    check("rst_nuds", {31'd0, nuds_o}, 32'd1);
    check("rst_rnw", {31'd0, rnw_o}, 32'd1);
    check("rst_doe", {31'd0, d_oe}, 32'd0);
    check("rst_addr", {18'd0, ah_o, al_o}, 32'd0);
    check("rst_cfgin", {31'd0, nconfigin_o}, 32'd1);
    check("rst_busy_done", {30'd0, busy, done}, 32'd0);
    check("rst_counts", {26'd0, cards, shut_cnt}, 32'd0);
    check("rst_next_free", {24'd0, next_free}, 32'h20);

    // 1) single 2MB card, auto start; a start pulse while busy must be ignored
    cpu_nreset = 1'b1;
    @(negedge cpu_clk);
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_cfgin", {31'd0, nconfigin_o}, 32'd0);
    repeat (20) @(negedge cpu_clk);
    pulse_start();
    wait_done("t1_done");
    check("t1_nreads", rd_cnt - rd_base, 32'd10);
    for (int k = 0; k < 9; k++)
      check($sformatf("t1_rd%0d", k), {26'd0, rd_al[rd_base + k]}, {26'd0, exp_rd[k]});
    check("t1_nwrites", wr_cnt - wr_base, 32'd2);
    check_wr("t1_wr0", 0, 6'h25, 4'h0);
    check_wr("t1_wr1", 1, 6'h24, 4'h2);
    check("t1_cards", {29'd0, cards}, 32'd1);
    check("t1_shut", {29'd0, shut_cnt}, 32'd0);
    check("t1_next_free", {24'd0, next_free}, 32'h40);
    check("t1_busy_end", {31'd0, busy}, 32'd0);

    // 2) empty chain: $00 read times out (strobe cycle + 64 wait cycles with /AS low)
    cpu_nreset = 1'b0;
    setup_chain(0, 8'h00, 8'h00, 8'h00);
    @(negedge cpu_clk);
    cpu_nreset = 1'b1;
    wait_done("t2_done");
    check("t2_nreads", rd_cnt - rd_base, 32'd1);
    check("t2_rd0", {26'd0, rd_al[rd_base]}, 32'd0);
    check("t2_as_len", last_low, 32'd65);
    check("t2_nwrites", wr_cnt - wr_base, 32'd0);
    check("t2_cards", {29'd0, cards}, 32'd0);

    // 3) restart from done: 2MB then 4MB
    setup_chain(2, 8'hE6, 8'hE7, 8'h00);
    pulse_start();
    wait_done("t3_done");
    check("t3_nwrites", wr_cnt - wr_base, 32'd4);
    check_wr("t3_wr1", 1, 6'h24, 4'h2);
    check_wr("t3_wr2", 2, 6'h25, 4'h0);
    check_wr("t3_wr3", 3, 6'h24, 4'h4);
    check("t3_cards", {29'd0, cards}, 32'd2);
    check("t3_next_free", {24'd0, next_free}, 32'h80);

    // 4) 8MB card cannot fit: shut up
    cpu_nreset = 1'b0;
    setup_chain(1, 8'hE0, 8'h00, 8'h00);
    @(negedge cpu_clk);
    cpu_nreset = 1'b1;
    wait_done("t4_done");
    check("t4_nwrites", wr_cnt - wr_base, 32'd1);
    check_wr("t4_wr0", 0, 6'h26, 4'h0);
    check("t4_shut", {29'd0, shut_cnt}, 32'd1);
    check("t4_cards", {29'd0, cards}, 32'd0);
    check("t4_next_free", {24'd0, next_free}, 32'h20);

    // 5) 64KB card leaves next_free=$21, then 512KB aligns to $28
    setup_chain(2, 8'hE1, 8'hE4, 8'h00);
    pulse_start();
    wait_done("t5_done");
    check("t5_nwrites", wr_cnt - wr_base, 32'd4);
    check_wr("t5_wr1", 1, 6'h24, 4'h2);
    check_wr("t5_wr2", 2, 6'h25, 4'h8);
    check_wr("t5_wr3", 3, 6'h24, 4'h2);
    check("t5_next_free", {24'd0, next_free}, 32'h30);
    check("t5_cards", {29'd0, cards}, 32'd2);

    // 7) invalid type shut, 4MB at $40, second 4MB would end past $A0 so shut
    setup_chain(3, 8'hA6, 8'hE7, 8'hE7);
    pulse_start();
    wait_done("t7_done");
    check("t7_nwrites", wr_cnt - wr_base, 32'd4);
    check_wr("t7_wr0", 0, 6'h26, 4'h0);
    check_wr("t7_wr2", 2, 6'h24, 4'h4);
    check_wr("t7_wr3", 3, 6'h26, 4'h0);
    check("t7_shut", {29'd0, shut_cnt}, 32'd2);
    check("t7_cards", {29'd0, cards}, 32'd1);
    check("t7_next_free", {24'd0, next_free}, 32'h80);

    // 6) reset while waiting on the $48 write, then a clean rerun
    cpu_nreset = 1'b0;
    setup_chain(1, 8'hE6, 8'h00, 8'h00);
    ack_block = 1'b1;
    @(negedge cpu_clk);
    cpu_nreset = 1'b1;
    n = 0;
    while (!(!nas_o && !rnw_o && al_o == 6'h24) && n < 2000) begin
      @(negedge cpu_clk);
      n++;
    end
    check("t6_reach_wr48", {31'd0, (!nas_o && !rnw_o && al_o == 6'h24)}, 32'd1);
    repeat (10) @(negedge cpu_clk);
    #2 cpu_nreset = 1'b0;
    #1;
    check("t6_nas_nuds", {30'd0, nas_o, nuds_o}, 32'd3);
    check("t6_doe", {31'd0, d_oe}, 32'd0);
    check("t6_cfgin", {31'd0, nconfigin_o}, 32'd1);
    check("t6_busy", {31'd0, busy}, 32'd0);
    @(negedge cpu_clk);
    ack_block = 1'b0;
    setup_chain(1, 8'hE6, 8'h00, 8'h00);
    cpu_nreset = 1'b1;
    wait_done("t6_done");
    check("t6_rd0", {26'd0, rd_al[rd_base]}, 32'd0);
    check("t6_nwrites", wr_cnt - wr_base, 32'd2);
    check_wr("t6_wr1", 1, 6'h24, 4'h2);
    check("t6_cards", {29'd0, cards}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
